pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central pipeline sequencer for the five-stage no-delay-slot MIPS core. It generates the PC write enable and the 2-bit `choice` code for each of the four stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB): 00 = flush to zero, 01 = load, 10 = hold. It resolves load-use stalls, branch/jump flushes, data-memory wait and multi-cycle multiply/divide occupancy through a small state machine, so that no stage register is driven by more than one ad-hoc source.

## Interface
- `MD_LATENCY`, 4: cycles a mult/div op occupies EX, legal range 2..64.
- `PERF_W`, 32: width of the performance counters.

- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`  in  1 each  the ID instruction reads rs / rt.
- `id_jump`  in  1  unconditional jump decoded in ID.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_wr_reg`  in  5  destination register of the instruction in EX.
- `ex_redirect`  in  1  branch taken, resolved in EX.
- `md_start`  in  1  level: mult/div op present in EX.
- `mem_wait`  in  1  data memory not ready this cycle.
- `pc_we`  out  1  PC register load enable.
- `ifid_choice`, `idex_choice`, `exmem_choice`, `memwb_choice`  out  2 each  stage register control.
- `md_busy`  out  1  state is MD_BUSY.
- `md_done`  out  1  one-cycle pulse on the mult/div advance cycle.
- `stall_cycles`, `flush_count`  out  PERF_W each  performance counters.

## Operation
- States: RUN, MD_BUSY. 6-bit down counter `cnt`.
- Outputs are combinational from state, `cnt` and inputs. Priority is highest first:
  1. `reset`=1: all choices 00, `pc_we`=0, `md_done`=0.
  2. `mem_wait`: all choices 10, `pc_we`=0.
  3. MD stall (RUN with `md_start`, or MD_BUSY with `cnt`≠0): `pc_we`=0, IF/ID 10, ID/EX 10, EX/MEM 00, MEM/WB 01.
  4. `ex_redirect`: `pc_we`=1, IF/ID 00, ID/EX 00, EX/MEM 01, MEM/WB 01.
  5. Load-use: requires `ex_mem_read`, `ex_wr_reg`≠0, and (`id_uses_rs` with `id_rs`==`ex_wr_reg`) or (`id_uses_rt` with `id_rt`==`ex_wr_reg`). Response: `pc_we`=0, IF/ID 10, ID/EX 00, EX/MEM 01, MEM/WB 01.
  6. `id_jump`: `pc_we`=1, IF/ID 00, others 01.
  7. Normal: `pc_we`=1, all choices 01.
- Code 11 is never driven.
- Transitions are evaluated only when `mem_wait`=0. With `mem_wait`=1, state and `cnt` are frozen.
  - RUN with `md_start` → MD_BUSY, `cnt`←MD_LATENCY−2.
  - MD_BUSY with `cnt`≠0: `cnt`←`cnt`−1.
  - MD_BUSY with `cnt`==0 → RUN. That cycle is the advance cycle: `md_start` is ignored, `md_done`=1, and rules 4–7 apply.
- Total: the op spends MD_LATENCY−1 stall cycles in EX and advances on cycle MD_LATENCY.
- `ex_redirect` and `md_start` are mutually exclusive by construction. If both are asserted, MD wins.
- `md_busy`=1 exactly while state is MD_BUSY.

## Timing
- Reset: state RUN, `cnt`=0, counters 0. While `reset` is high, outputs are as in rule 1. First normal outputs appear in the cycle after `reset` falls.
- Reset mid-MD_BUSY: state returns to RUN, `cnt`=0, no `md_done`.
- Choice and `pc_we` take effect at the next rising edge of `clk`; there is zero-cycle combinational latency from inputs.
- A load-use stall lasts exactly one cycle: the load has moved to MEM next cycle, so `ex_mem_read` drops.

## Configuration
- `PIPE_HAZARD_CTRL_PERF_EN` defined:
  - `stall_cycles` increments on every non-reset cycle with `pc_we`=0.
  - `flush_count` increments on every non-reset cycle with `ifid_choice`=00.
  - Both saturate at all-ones.
- Not defined: no counter registers are built, and both outputs are tied to 0.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_wr_reg`=5, `id_rs`=5, `id_uses_rs`=1 → one cycle of `pc_we`=0, IF/ID 10, ID/EX 00, EX/MEM 01. The next cycle is normal. With `ex_wr_reg`=0, no stall occurs.
- Redirect: `ex_redirect`=1 → `pc_we`=1, IF/ID 00, ID/EX 00. With `ex_redirect` and `id_jump` asserted together, redirect wins.
- Mult/div, MD_LATENCY=4, `md_start` held: stall pattern for 3 cycles (`md_busy` 0,1,1), then advance cycle with `md_done`=1 and all choices 01. State then returns to RUN.
- `mem_wait` asserted for 2 cycles during MD_BUSY with `cnt`=1: all choices 10 and `cnt` frozen. After release, total stall cycles = 3 + 2.
- `reset` mid-MD_BUSY: next cycle RUN, `md_busy`=0, all choices 00 during reset.
- PERF_EN build: 3 MD stalls + 1 load-use + 1 redirect → `stall_cycles`=4, `flush_count`=1. Non-PERF build: both read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - central stall/flush sequencer for the five-stage MIPS pipeline
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN (builds the stall/flush performance counters)
module pipe_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_jump,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_wr_reg,
  input  logic              ex_redirect,
  input  logic              md_start,
  input  logic              mem_wait,
  output logic              pc_we,
  output logic [1:0]        ifid_choice,
  output logic [1:0]        idex_choice,
  output logic [1:0]        exmem_choice,
  output logic [1:0]        memwb_choice,
  output logic              md_busy,
  output logic              md_done,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  localparam logic [1:0] CH_FLUSH = 2'b00;
  localparam logic [1:0] CH_LOAD  = 2'b01;
  localparam logic [1:0] CH_HOLD  = 2'b10;

  // The entry cycle in RUN is the first stall, and the cnt==0 cycle is the advance,
  // so the counter is loaded with two less than the total occupancy.
  localparam logic [5:0] MD_CNT_INIT = 6'(MD_LATENCY - 2);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  logic load_use;
  logic md_stall;
  logic md_advance;

  // Classify the hazards present this cycle
  always_comb begin
    load_use   = ex_mem_read && (ex_wr_reg != 5'd0) &&
                 ((id_uses_rs && (id_rs == ex_wr_reg)) ||
                  (id_uses_rt && (id_rt == ex_wr_reg)));
    md_stall   = ((state_q == ST_RUN) && md_start) ||
                 ((state_q == ST_MD_BUSY) && (cnt_q != 6'd0));
    md_advance = (state_q == ST_MD_BUSY) && (cnt_q == 6'd0);
  end

  // Prioritised stage-register control; a single source drives every choice code
  always_comb begin
    pc_we        = 1'b1;
    ifid_choice  = CH_LOAD;
    idex_choice  = CH_LOAD;
    exmem_choice = CH_LOAD;
    memwb_choice = CH_LOAD;
    md_done      = 1'b0;
    if (reset) begin
      pc_we        = 1'b0;
      ifid_choice  = CH_FLUSH;
      idex_choice  = CH_FLUSH;
      exmem_choice = CH_FLUSH;
      memwb_choice = CH_FLUSH;
    end else if (mem_wait) begin
      pc_we        = 1'b0;
      ifid_choice  = CH_HOLD;
      idex_choice  = CH_HOLD;
      exmem_choice = CH_HOLD;
      memwb_choice = CH_HOLD;
    end else if (md_stall) begin
      // Op stays in EX; a bubble goes to MEM while older work drains to WB
      pc_we        = 1'b0;
      ifid_choice  = CH_HOLD;
      idex_choice  = CH_HOLD;
      exmem_choice = CH_FLUSH;
      memwb_choice = CH_LOAD;
    end else begin
      // The mult/div advance cycle falls through to the ordinary rules below
      md_done = md_advance;
      if (ex_redirect) begin
        ifid_choice = CH_FLUSH;
        idex_choice = CH_FLUSH;
      end else if (load_use) begin
        pc_we       = 1'b0;
        ifid_choice = CH_HOLD;
        idex_choice = CH_FLUSH;
      end else if (id_jump) begin
        ifid_choice = CH_FLUSH;
      end
    end
  end

  assign md_busy = (state_q == ST_MD_BUSY);

  // Mult/div occupancy sequencing; frozen while data memory stalls the pipe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_wait) begin
      case (state_q)
        ST_RUN: begin
          if (md_start) begin
            state_d = ST_MD_BUSY;
            cnt_d   = MD_CNT_INIT;
          end
        end
        ST_MD_BUSY: begin
          if (cnt_q != 6'd0) begin
            cnt_d = cnt_q - 6'd1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0] flush_count_q, flush_count_d;

  // Saturating counts of PC-hold cycles and IF/ID flush cycles
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_we && (stall_cycles_q != PERF_MAX)) begin
      stall_cycles_d = stall_cycles_q + PERF_ONE;
    end
    if ((ifid_choice == CH_FLUSH) && (flush_count_q != PERF_MAX)) begin
      flush_count_d = flush_count_q + PERF_ONE;
    end
  end

  // Performance counter registers; reset cycles are never counted
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized model-checked bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int MD_LAT = 4;
  localparam int PW     = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_wr_reg;
  logic          id_uses_rs, id_uses_rt, id_jump, ex_mem_read, ex_redirect, md_start, mem_wait;
  logic          pc_we, md_busy, md_done;
  logic [1:0]    ifid_choice, idex_choice, exmem_choice, memwb_choice;
  logic [PW-1:0] stall_cycles, flush_count;

  pipe_hazard_ctrl #(.MD_LATENCY(MD_LAT), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_wr_reg(ex_wr_reg),
    .ex_redirect(ex_redirect), .md_start(md_start), .mem_wait(mem_wait),
    .pc_we(pc_we), .ifid_choice(ifid_choice), .idex_choice(idex_choice),
    .exmem_choice(exmem_choice), .memwb_choice(memwb_choice),
    .md_busy(md_busy), .md_done(md_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: m_age = -1 when no mult/div op holds EX, otherwise the
  // number of non-waiting cycles the op has already spent in EX.
  int       m_age   = -1;
  longint   m_stall = 0;
  longint   m_flush = 0;
  bit       m_valid = 0;
  logic       e_pc, e_done, e_busy;
  logic [1:0] e_ifid, e_idex, e_exmem, e_memwb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_ch(input logic p, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d);
    e_pc = p; e_ifid = a; e_idex = b; e_exmem = c; e_memwb = d;
  endtask

  task automatic model_eval();
    bit stall_m, adv_m, lu;
    stall_m = (m_age < 0 && md_start) || (m_age >= 1 && m_age + 1 < MD_LAT);
    adv_m   = (m_age >= 1) && (m_age + 1 == MD_LAT);
    lu      = ex_mem_read && ex_wr_reg != 0 &&
              ((id_uses_rs && id_rs == ex_wr_reg) || (id_uses_rt && id_rt == ex_wr_reg));
    e_busy = (m_age >= 1);
    e_done = 1'b0;
    if (reset)            set_ch(0, 2'd0, 2'd0, 2'd0, 2'd0);
    else if (mem_wait)    set_ch(0, 2'd2, 2'd2, 2'd2, 2'd2);
    else if (stall_m)     set_ch(0, 2'd2, 2'd2, 2'd0, 2'd1);
    else begin
      e_done = adv_m;
      if (ex_redirect)    set_ch(1, 2'd0, 2'd0, 2'd1, 2'd1);
      else if (lu)        set_ch(0, 2'd2, 2'd0, 2'd1, 2'd1);
      else if (id_jump)   set_ch(1, 2'd0, 2'd1, 2'd1, 2'd1);
      else                set_ch(1, 2'd1, 2'd1, 2'd1, 2'd1);
    end
  endtask

  task automatic model_edge();
    longint sat;
    sat = (64'd1 << PW) - 1;
    if (reset) begin
      m_age = -1; m_stall = 0; m_flush = 0; m_valid = 1;
    end else begin
      if (!e_pc && m_stall < sat) m_stall++;
      if (e_ifid == 2'd0 && m_flush < sat) m_flush++;
      if (!mem_wait) begin
        if (m_age < 0) begin
          if (md_start) m_age = 1;
        end else if (m_age + 1 == MD_LAT) m_age = -1;
        else m_age++;
      end
    end
  endtask

  // Let combinational outputs settle, then compare everything against the model
  task automatic settle();
    longint xs, xf;
    #2;
    model_eval();
    chk("pc_we", pc_we, e_pc);
    chk("ifid_choice", ifid_choice, e_ifid);
    chk("idex_choice", idex_choice, e_idex);
    chk("exmem_choice", exmem_choice, e_exmem);
    chk("memwb_choice", memwb_choice, e_memwb);
    chk("md_done", md_done, e_done);
    if (m_valid) begin
      chk("md_busy", md_busy, e_busy);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      xs = m_stall; xf = m_flush;
`else
      xs = 0; xf = 0;
`endif
      chk("stall_cycles", stall_cycles, xs[PW-1:0]);
      chk("flush_count", flush_count, xf[PW-1:0]);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_jump = 0;
    ex_mem_read = 0; ex_wr_reg = 0; ex_redirect = 0; md_start = 0; mem_wait = 0;
  endtask

  initial begin
    int stalls;
    bit done_seen;
    clear_inputs();
    reset = 1;
    @(posedge clk); model_edge(); #1;
    // Reset held: everything flushes
    settle();
    chk("rst_pc_we", pc_we, 1'b0);
    chk("rst_ifid", ifid_choice, 2'b00);
    chk("rst_memwb", memwb_choice, 2'b00);
    chk("rst_stall_cnt", stall_cycles, 0);
    advance();
    reset = 0;
    settle();
    chk("norm_pc_we", pc_we, 1'b1);
    chk("norm_exmem", exmem_choice, 2'b01);
    advance();

    // Mult/div with md_start held: three stalls then the advance cycle
    md_start = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("md_stall_pc_we", pc_we, 1'b0);
      chk("md_stall_exmem", exmem_choice, 2'b00);
      chk("md_stall_ifid", ifid_choice, 2'b10);
      chk("md_busy_seq", md_busy, (i == 0) ? 1'b0 : 1'b1);
      advance();
    end
    settle();
    chk("md_adv_done", md_done, 1'b1);
    chk("md_adv_pc_we", pc_we, 1'b1);
    chk("md_adv_idex", idex_choice, 2'b01);
    advance();
    md_start = 0;
    settle();
    chk("md_back_run", md_busy, 1'b0);
    advance();

    // Load-use stall lasts one cycle
    ex_mem_read = 1; ex_wr_reg = 5; id_rs = 5; id_uses_rs = 1;
    settle();
    chk("lu_pc_we", pc_we, 1'b0);
    chk("lu_ifid", ifid_choice, 2'b10);
    chk("lu_idex", idex_choice, 2'b00);
    chk("lu_exmem", exmem_choice, 2'b01);
    advance();
    ex_mem_read = 0;
    settle();
    chk("lu_next_pc_we", pc_we, 1'b1);
    advance();
    ex_mem_read = 1; ex_wr_reg = 0; id_rs = 0;
    settle();
    chk("lu_r0_pc_we", pc_we, 1'b1);
    advance();
    clear_inputs();

    // Redirect beats jump
    ex_redirect = 1; id_jump = 1;
    settle();
    chk("redir_pc_we", pc_we, 1'b1);
    chk("redir_ifid", ifid_choice, 2'b00);
    chk("redir_idex", idex_choice, 2'b00);
    chk("redir_exmem", exmem_choice, 2'b01);
    advance();
    clear_inputs();
    settle();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk("perf_stall_lit", stall_cycles, 4);
    chk("perf_flush_lit", flush_count, 1);
`else
    chk("perf_stall_lit", stall_cycles, 0);
    chk("perf_flush_lit", flush_count, 0);
`endif
    advance();

    // mem_wait for two cycles while cnt==1 stretches the op to 3 + 2 stalls
    md_start = 1; stalls = 0; done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      mem_wait = (i == 2 || i == 3);
      settle();
      if (i == 2) begin
        chk("mw_ifid", ifid_choice, 2'b10);
        chk("mw_exmem", exmem_choice, 2'b10);
        chk("mw_busy", md_busy, 1'b1);
      end
      if (md_done) begin
        done_seen = 1;
        advance();
        break;
      end
      if (!pc_we) stalls++;
      advance();
    end
    chk("mw_done_seen", done_seen, 1'b1);
    chk("mw_total_stalls", stalls, 5);
    clear_inputs();

    // Reset in the middle of MD_BUSY
    md_start = 1;
    settle(); advance();
    settle(); advance();
    reset = 1;
    settle();
    chk("rstmd_ifid", ifid_choice, 2'b00);
    chk("rstmd_done", md_done, 1'b0);
    advance();
    clear_inputs();
    settle();
    chk("rstmd_busy", md_busy, 1'b0);
    chk("rstmd_pc_we", pc_we, 1'b1);
    advance();

    // Randomized traffic with small register indices so hazards collide often
    for (int n = 0; n < 4000; n++) begin
      reset       = ($urandom_range(0, 59) == 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_uses_rs  = 1'($urandom_range(0, 1));
      id_uses_rt  = 1'($urandom_range(0, 1));
      id_jump     = ($urandom_range(0, 7) == 0);
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_wr_reg   = 5'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 7) == 0);
      md_start    = ($urandom_range(0, 5) == 0);
      mem_wait    = ($urandom_range(0, 5) == 0);
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
